viterbi_link_ctrl: RTL and testbench

Frame sequencer and scheduler for the convolutional-encoder / Viterbi-decoder link.
- Latches a payload word and serializes it, plus zero tail bits, into the encoder.
- Forwards the encoder valid as the decoder enable and schedules channel bit-error injection.
- Captures the decoder output bits and compares them with the sent payload.
- Keeps bit-error and injection statistics and reports completion with a done pulse.

---
 rtl/viterbi_link_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_viterbi_link_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer for the convolutional-encoder / Viterbi-decoder link: serializes a payload,
// captures the decoded bits and keeps error statistics. Channel error injection: VITERBI_ERR_INJ_EN.
module viterbi_link_ctrl #(
    parameter int FRAME_LEN = 32,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 20,
    parameter int ERR_N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [FRAME_LEN-1:0] payload_i,
    input  logic                 clr_stats_i,
    output logic                 enc_enable_o,
    output logic                 enc_bit_o,
    input  logic                 enc_valid_i,
    output logic                 dec_enable_o,
    output logic [1:0]           err_inj_o,
    input  logic                 dec_bit_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [FRAME_LEN-1:0] rx_word_o,
    output logic [15:0]          bit_err_ct_o,
    output logic [15:0]          inj_ct_o
);
    // state | meaning
    // IDLE  | waiting for start_i
    // SEND  | payload + tail bits streamed into the encoder
    // WAIT  | collecting decoded payload bits, watchdog running
    // CHECK | one-cycle compare, statistics update, done_o pulse
    typedef enum logic [1:0] {IDLE, SEND, WAIT, CHECK} state_t;

    localparam int SEND_LEN = FRAME_LEN + TAIL_LEN;
    localparam int WD_LEN   = DEC_LAT + FRAME_LEN + TAIL_LEN + 16;
    localparam int SEND_W   = $clog2(SEND_LEN + 1);
    localparam int WD_W     = $clog2(WD_LEN + 1);

    state_t               state;
    logic [FRAME_LEN-1:0] payload;
    logic [FRAME_LEN-1:0] tx_sr;
    logic [SEND_W-1:0]    send_cnt;
    logic [WD_W-1:0]      wd_cnt;
    logic [DEC_LAT-1:0]   dec_pipe;
    logic [6:0]           cap_cnt;
    logic                 cap_fire;
    logic                 cap_last;
    logic [6:0]           err_pop;
    logic [16:0]          err_sum;

    function automatic logic [6:0] popcnt(input logic [FRAME_LEN-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < FRAME_LEN; i++) c = c + 7'(v[i]);
        return c;
    endfunction

    assign cap_fire = dec_pipe[DEC_LAT-1] && (cap_cnt < 7'(FRAME_LEN));
    // Look ahead so CHECK starts in the cycle right after the last payload capture.
    assign cap_last = (cap_cnt == 7'(FRAME_LEN)) || (cap_fire && cap_cnt == 7'(FRAME_LEN - 1));

    always_comb begin
        err_pop = popcnt(rx_word_o ^ payload);
        err_sum = {1'b0, bit_err_ct_o} + {10'b0, err_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            payload      <= '0;
            tx_sr        <= '0;
            send_cnt     <= '0;
            wd_cnt       <= '0;
            dec_pipe     <= '0;
            cap_cnt      <= '0;
            rx_word_o    <= '0;
            enc_enable_o <= 1'b0;
            enc_bit_o    <= 1'b0;
            dec_enable_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            dec_enable_o <= enc_valid_i;
            dec_pipe     <= {dec_pipe[DEC_LAT-2:0], dec_enable_o};
            if (cap_fire) begin
                rx_word_o <= {rx_word_o[FRAME_LEN-2:0], dec_bit_i};
                cap_cnt   <= cap_cnt + 7'd1;
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        payload      <= payload_i;
                        tx_sr        <= {payload_i[FRAME_LEN-2:0], 1'b0};
                        enc_bit_o    <= payload_i[FRAME_LEN-1];
                        enc_enable_o <= 1'b1;
                        busy_o       <= 1'b1;
                        timeout_o    <= 1'b0;
                        cap_cnt      <= '0;
                        rx_word_o    <= '0;
                        send_cnt     <= SEND_W'(SEND_LEN - 1);
                        wd_cnt       <= WD_W'(WD_LEN - 1);
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (send_cnt == '0) begin
                        enc_enable_o <= 1'b0;
                        enc_bit_o    <= 1'b0;
                        state        <= WAIT;
                    end else begin
                        send_cnt  <= send_cnt - 1'b1;
                        enc_bit_o <= tx_sr[FRAME_LEN-1];
                        tx_sr     <= {tx_sr[FRAME_LEN-2:0], 1'b0};
                    end
                end
                WAIT: begin
                    if (cap_last) begin
                        done_o <= 1'b1;
                        state  <= CHECK;
                    end else if (wd_cnt == '0) begin
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        state     <= CHECK;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_err_ct_o <= '0;
        end else if (clr_stats_i) begin
            bit_err_ct_o <= '0;
        end else if (state == CHECK) begin
            bit_err_ct_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

`ifdef VITERBI_ERR_INJ_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [16:0] inj_sum;

    // Fibonacci form, taps 16,14,13,11, shifting toward bit 0.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign inj_sum = {1'b0, inj_ct_o} + {16'b0, err_inj_o[1]} + {16'b0, err_inj_o[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr      <= 16'hACE1;
            err_inj_o <= 2'b00;
        end else begin
            if (enc_valid_i) lfsr <= {lfsr_fb, lfsr[15:1]};
            err_inj_o <= (enc_valid_i && (&lfsr[ERR_N-1:0])) ? 2'b11 : 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_ct_o <= '0;
        end else if (clr_stats_i) begin
            inj_ct_o <= '0;
        end else begin
            inj_ct_o <= inj_sum[16] ? 16'hFFFF : inj_sum[15:0];
        end
    end
`else
    assign err_inj_o = 2'b00;
    assign inj_ct_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Directed bench for viterbi_link_ctrl: ideal encoder/decoder models around the DUT,
// table-driven frames plus hand sequences for start hold, reset abort and statistics clear.
module tb_viterbi_link_ctrl;
    localparam int FRAME_LEN = 32;
    localparam int TAIL_LEN  = 2;
    localparam int DEC_LAT   = 20;
    localparam int ERR_N     = 4;
    localparam int SEND_LEN  = FRAME_LEN + TAIL_LEN;
    localparam int WD_LEN    = DEC_LAT + FRAME_LEN + TAIL_LEN + 16;
    // first decoded bit lands in cycle 3+DEC_LAT, last one FRAME_LEN-1 later, done the cycle after
    localparam int DONE_OK   = 3 + DEC_LAT + FRAME_LEN;
    localparam int DONE_TO   = 1 + SEND_LEN + WD_LEN;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start_i = 1'b0;
    logic [FRAME_LEN-1:0] payload_i = '0;
    logic                 clr_stats_i = 1'b0;
    logic                 enc_enable_o, enc_bit_o;
    logic                 enc_valid_i = 1'b0;
    logic                 dec_enable_o;
    logic [1:0]           err_inj_o;
    logic                 dec_bit_i = 1'b0;
    logic                 busy_o, done_o, timeout_o;
    logic [FRAME_LEN-1:0] rx_word_o;
    logic [15:0]          bit_err_ct_o, inj_ct_o;

    viterbi_link_ctrl #(.FRAME_LEN(FRAME_LEN), .TAIL_LEN(TAIL_LEN), .DEC_LAT(DEC_LAT), .ERR_N(ERR_N)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .payload_i(payload_i), .clr_stats_i(clr_stats_i),
        .enc_enable_o(enc_enable_o), .enc_bit_o(enc_bit_o), .enc_valid_i(enc_valid_i),
        .dec_enable_o(dec_enable_o), .err_inj_o(err_inj_o), .dec_bit_i(dec_bit_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .rx_word_o(rx_word_o),
        .bit_err_ct_o(bit_err_ct_o), .inj_ct_o(inj_ct_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_err  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Encoder/decoder/channel models, all driven mid-cycle.
    logic [DEC_LAT:0]     hist = '0;
    logic                 en_prev = 1'b0;
    logic                 kill_valid = 1'b0;
    int                   sym_cnt = 0;
    logic [FRAME_LEN-1:0] model_payload = '0;
    logic [FRAME_LEN-1:0] flip_mask = '0;
    int                   inj_bad = 0;
    int                   ref_inj_cnt = 0;
`ifdef VITERBI_ERR_INJ_EN
    logic [15:0]          ref_lfsr = 16'hACE1;
    logic                 inj_pend = 1'b0;
`endif

    always @(negedge clk) begin
        if (!rst) begin
            hist = '0; en_prev = 1'b0; enc_valid_i = 1'b0; dec_bit_i = 1'b0; ref_inj_cnt = 0;
`ifdef VITERBI_ERR_INJ_EN
            ref_lfsr = 16'hACE1; inj_pend = 1'b0;
`endif
        end else begin
`ifdef VITERBI_ERR_INJ_EN
            if (err_inj_o !== (inj_pend ? 2'b11 : 2'b00)) inj_bad++;
            if (inj_pend) ref_inj_cnt += 2;
`else
            if (err_inj_o !== 2'b00) inj_bad++;
`endif
            enc_valid_i = kill_valid ? 1'b0 : en_prev;
            en_prev     = enc_enable_o;
            hist        = {hist[DEC_LAT-1:0], dec_enable_o};
            dec_bit_i   = 1'b0;
            if (hist[DEC_LAT]) begin
                if (sym_cnt < FRAME_LEN)
                    dec_bit_i = model_payload[FRAME_LEN-1-sym_cnt] ^ flip_mask[sym_cnt];
                sym_cnt++;
            end
`ifdef VITERBI_ERR_INJ_EN
            inj_pend = enc_valid_i && (ref_lfsr[ERR_N-1:0] == {ERR_N{1'b1}});
            if (enc_valid_i)
                ref_lfsr = {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
`endif
        end
    end

    typedef struct {
        logic [31:0] payload;
        logic [31:0] flip;       // bit k set: decoder inverts capture k
        bit          kill;       // encoder never raises valid
        bit          clr_at_check;
        logic [31:0] exp_rx;
        int          exp_delta;
        int          exp_done;
        bit          exp_to;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int idx, input vec_t v);
        int done_at, ndone, enc_bad, busy_bad;
        logic en_exp, bit_exp, busy_exp;
        done_at = -1; ndone = 0; enc_bad = 0; busy_bad = 0;
        @(negedge clk);
        model_payload = v.payload; flip_mask = v.flip; kill_valid = v.kill; sym_cnt = 0;
        payload_i = v.payload; start_i = 1'b1;
        for (int r = 1; r <= 200; r++) begin
            @(negedge clk);
            start_i = 1'b0; clr_stats_i = 1'b0;
            en_exp  = (r <= SEND_LEN);
            bit_exp = 1'b0;
            if (r <= FRAME_LEN) bit_exp = v.payload[FRAME_LEN-r];
            if (enc_enable_o !== en_exp || (en_exp && enc_bit_o !== bit_exp)) enc_bad++;
            if (done_o === 1'b1) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = r;
                    check($sformatf("v%0d_rx_word", idx), rx_word_o, v.exp_rx);
                    check($sformatf("v%0d_timeout", idx), timeout_o, v.exp_to);
                    if (v.clr_at_check) clr_stats_i = 1'b1;
                end
            end
            busy_exp = (done_at < 0) || (r == done_at);
            if (busy_o !== busy_exp) busy_bad++;
            if (done_at > 0 && r == done_at + 2) break;
        end
        start_i = 1'b0; clr_stats_i = 1'b0; kill_valid = 1'b0;
        if (v.clr_at_check) exp_err = 0; else exp_err += v.exp_delta;
        check($sformatf("v%0d_done_cycle", idx), done_at, v.exp_done);
        check($sformatf("v%0d_done_pulses", idx), ndone, 1);
        check($sformatf("v%0d_enc_stream_bad", idx), enc_bad, 0);
        check($sformatf("v%0d_busy_bad", idx), busy_bad, 0);
        check($sformatf("v%0d_bit_err_ct", idx), bit_err_ct_o, exp_err);
        check($sformatf("v%0d_timeout_sticky", idx), timeout_o, v.exp_to);
    endtask

    task automatic clr_stats();
        @(negedge clk);
        clr_stats_i = 1'b1; ref_inj_cnt = 0;
        @(negedge clk);
        clr_stats_i = 1'b0; exp_err = 0;
        @(negedge clk);
        check("clr_bit_err_ct", bit_err_ct_o, 16'h0);
        check("clr_inj_ct", inj_ct_o, 16'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: simulation did not finish, expected finish before limit");
        $fatal(1);
    end

    initial begin
        int ndone, done_at, restart_bad;
        vecs[0] = '{32'hA5A5_0F0F, 32'h0000_0000, 1'b0, 1'b0, 32'hA5A5_0F0F, 0,  DONE_OK, 1'b0};
        vecs[1] = '{32'hA5A5_0F0F, 32'h8000_0001, 1'b0, 1'b0, 32'h25A5_0F0E, 2,  DONE_OK, 1'b0};
        vecs[2] = '{32'hA5A5_0F0F, 32'h8000_0001, 1'b0, 1'b0, 32'h25A5_0F0E, 2,  DONE_OK, 1'b0};
        vecs[3] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 32'h1A34_5678, 1,  DONE_OK, 1'b0};
        vecs[4] = '{32'hA5A5_0F0F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 16, DONE_TO, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_5678, 0,  DONE_OK, 1'b0};
        vecs[6] = '{32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1,  DONE_OK, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {enc_enable_o, enc_bit_o, dec_enable_o, err_inj_o, busy_o, done_o,
                                timeout_o, rx_word_o, bit_err_ct_o, inj_ct_o}, 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // start held for 40 cycles: exactly one frame
        @(negedge clk);
        model_payload = 32'hA5A5_0F0F; flip_mask = '0; sym_cnt = 0;
        payload_i = 32'hA5A5_0F0F; start_i = 1'b1;
        ndone = 0; done_at = -1; restart_bad = 0;
        for (int r = 1; r <= 120; r++) begin
            @(negedge clk);
            if (r == 40) start_i = 1'b0;
            if (done_o === 1'b1) begin ndone++; done_at = r; end
            if (r > SEND_LEN && enc_enable_o !== 1'b0) restart_bad++;
        end
        check("hold40_done_pulses", ndone, 1);
        check("hold40_done_cycle", done_at, DONE_OK);
        check("hold40_no_restart", restart_bad, 0);

        // start held through completion: second frame only after IDLE is re-entered
        @(negedge clk);
        sym_cnt = 0; start_i = 1'b1; ndone = 0; done_at = -1;
        for (int r = 1; r <= 130; r++) begin
            @(negedge clk);
            if (r == 60) sym_cnt = 0;
            if (r == 70) start_i = 1'b0;
            if (r == DONE_OK + 1) begin
                check("hold_idle_busy", busy_o, 1'b0);
                check("hold_idle_enc_en", enc_enable_o, 1'b0);
            end
            if (r == DONE_OK + 2) check("hold_restart_enc_en", enc_enable_o, 1'b1);
            if (done_o === 1'b1) begin
                ndone++; done_at = r;
                check($sformatf("hold_rx_word_%0d", ndone), rx_word_o, 32'hA5A5_0F0F);
            end
        end
        check("hold_done_pulses", ndone, 2);
        check("hold_second_done_cycle", done_at, 2 * DONE_OK + 1);

        // reset in the middle of SEND aborts the frame
        @(negedge clk);
        model_payload = 32'hDEAD_BEEF; sym_cnt = 0; payload_i = 32'hDEAD_BEEF; start_i = 1'b1;
        ndone = 0;
        for (int r = 1; r <= 100; r++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (r == 10) begin
                rst = 1'b0;
                #1;
                check("abort_reset_outputs", {enc_enable_o, enc_bit_o, dec_enable_o, err_inj_o, busy_o,
                      done_o, timeout_o, rx_word_o, bit_err_ct_o, inj_ct_o}, 64'h0);
            end
            if (r == 13) rst = 1'b1;
            if (done_o === 1'b1) ndone++;
        end
        exp_err = 0;
        check("abort_no_done", ndone, 0);
        run_vec(7, vecs[0]);

`ifdef VITERBI_ERR_INJ_EN
        clr_stats();
        for (int f = 0; f < 256; f++) run_vec(100 + f, vecs[0]);
        repeat (3) @(negedge clk);
        check("inj_ct_vs_ref", inj_ct_o, ref_inj_cnt);
        check("err_inj_pattern_bad", inj_bad, 0);
`else
        check("err_inj_zero_bad", inj_bad, 0);
        check("inj_ct_zero", inj_ct_o, 16'h0);
`endif

        run_vec(8, vecs[1]);
        clr_stats();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
